// File: rtl/fetch_stage_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// fetch_stage_if : instruction-bus, decode-handshake and redirect signals
// Rev 1.0
// ============================================================================
interface fetch_stage_if;
    logic        ireq;
    logic [31:0] iaddr;
    logic        idata_ok;
    logic [31:0] idata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        valid_out;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        adel_out;

    modport master (
        output ireq, iaddr, valid_out, instr_out, pc_out, adel_out,
        input  idata_ok, idata, stall, redirect_valid, redirect_pc
    );

    modport slave (
        input  ireq, iaddr, valid_out, instr_out, pc_out, adel_out,
        output idata_ok, idata, stall, redirect_valid, redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// fetch_stage : MIPS fetch with skid buffer and delay-slot-aware redirect
// Rev 1.0
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
    input  wire logic       clk,
    input  wire logic       reset,
    fetch_stage_if.master   fs
);
    typedef enum logic [0:0] {
        S_FETCH = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc_f;
    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic        r_adel;
    logic        r_sk_valid;
    logic [31:0] r_sk_instr;
    logic [31:0] r_sk_pc;
    logic        r_sk_adel;
    logic        r_pend_valid;
    logic [31:0] r_pend_pc;

    logic        w_fetching;
    logic        w_misal;
    logic        w_complete;
    logic        w_free;
    logic [31:0] w_c_instr;
    logic [31:0] w_next_pc;

    assign w_fetching = (r_state == S_FETCH);
    assign w_misal    = (r_pc_f[1:0] != 2'b00);
    // A misaligned address completes on its own without touching the bus.
    assign w_complete = w_fetching & (w_misal | fs.idata_ok);
    assign w_free     = ~r_valid | ~fs.stall;
    assign w_c_instr  = w_misal ? 32'd0 : fs.idata;
    assign w_next_pc  = r_pend_valid ? r_pend_pc : r_pc_f + 32'd4;

    assign fs.ireq      = ~reset & w_fetching & ~w_misal;
    assign fs.iaddr     = r_pc_f;
    assign fs.valid_out = r_valid;
    assign fs.instr_out = r_instr;
    assign fs.pc_out    = r_pc;
    assign fs.adel_out  = r_adel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_FETCH;
            r_pc_f       <= RESET_PC;
            r_valid      <= 1'b0;
            r_instr      <= 32'd0;
            r_pc         <= 32'd0;
            r_adel       <= 1'b0;
            r_sk_valid   <= 1'b0;
            r_sk_instr   <= 32'd0;
            r_sk_pc      <= 32'd0;
            r_sk_adel    <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_pc    <= 32'd0;
        end else begin
            if (r_state == S_FETCH) begin
                if (w_complete) begin
                    if (w_free) begin
                        r_valid <= 1'b1;
                        r_instr <= w_c_instr;
                        r_pc    <= r_pc_f;
                        r_adel  <= w_misal;
                    end else begin
                        r_sk_valid <= 1'b1;
                        r_sk_instr <= w_c_instr;
                        r_sk_pc    <= r_pc_f;
                        r_sk_adel  <= w_misal;
                        r_state    <= S_FULL;
                    end
                end else if (w_free) begin
                    r_valid <= 1'b0;
                end
            end else begin
                if (w_free) begin
                    r_valid    <= 1'b1;
                    r_instr    <= r_sk_instr;
                    r_pc       <= r_sk_pc;
                    r_adel     <= r_sk_adel;
                    r_sk_valid <= 1'b0;
                    r_state    <= S_FETCH;
                end
            end

            if (w_complete) begin
                r_pc_f       <= w_next_pc;
                r_pend_valid <= 1'b0;
            end

            // Delay slot already fetched: jump now; otherwise defer to its completion.
            if (fs.redirect_valid) begin
                if (r_sk_valid || w_complete) begin
                    r_pc_f <= fs.redirect_pc;
                end else begin
                    r_pend_valid <= 1'b1;
                    r_pend_pc    <= fs.redirect_pc;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_fetch_stage : random bus/stall/redirect stimulus against a program-order model
// Rev 1.0
// ============================================================================
module tb_fetch_stage;
    localparam logic [31:0] C_RESET_PC = 32'hbfc0_0000;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    fetch_stage_if fsif();

    fetch_stage #(.RESET_PC(C_RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .fs    (fsif)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] arch_q[$];
    int          tests     = 0;
    int          fails     = 0;
    int          p_stall   = 0;
    int          p_redir   = 0;
    bit          zero_wait = 1'b1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Stimulus: stall and redirect decisions; expected output pushed on each accept.
    initial begin
        logic [31:0] p;
        logic [31:0] tgt;
        exp_t        e;
        int          r;
        bit          last_branch;
        last_branch         = 1'b0;
        fsif.stall          = 1'b0;
        fsif.redirect_valid = 1'b0;
        fsif.redirect_pc    = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            fsif.redirect_valid = 1'b0;
            if (reset) begin
                fsif.stall  = 1'b0;
                last_branch = 1'b0;
            end else begin
                r          = int'($urandom_range(0, 99));
                fsif.stall = (r < p_stall);
                if (fsif.valid_out && !fsif.stall) begin
                    if (arch_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL model_empty: got empty program queue, required an entry");
                        arch_q.push_back(C_RESET_PC);
                    end
                    p       = arch_q.pop_front();
                    e.pc    = p;
                    e.adel  = (p[1:0] != 2'b00);
                    e.instr = e.adel ? 32'd0 : mem_word(p);
                    sb_q.push_back(e);
                    if (arch_q.size() == 0) arch_q.push_back(p + 32'd4);
                    r = int'($urandom_range(0, 99));
                    if (!last_branch && r < p_redir) begin
                        tgt = {C_RESET_PC[31:12], 10'($urandom), 2'b00};
                        r   = int'($urandom_range(0, 99));
                        if (r < 15) tgt = tgt + 32'd2;
                        while (arch_q.size() > 1) void'(arch_q.pop_back());
                        arch_q.push_back(tgt);
                        fsif.redirect_valid = 1'b1;
                        fsif.redirect_pc    = tgt;
                        last_branch         = 1'b1;
                    end else begin
                        last_branch = 1'b0;
                    end
                end
            end
        end
    end

    // Instruction bus responder with random or zero wait states.
    initial begin
        bit          busy;
        int          lat;
        logic [31:0] hold;
        busy          = 1'b0;
        lat           = 0;
        hold          = 32'd0;
        fsif.idata_ok = 1'b0;
        fsif.idata    = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            fsif.idata_ok = 1'b0;
            fsif.idata    = $urandom;
            if (reset) begin
                busy = 1'b0;
            end else if (fsif.ireq) begin
                check("ireq_aligned", {30'd0, fsif.iaddr[1:0]}, 32'd0);
                if (!busy) begin
                    busy = 1'b1;
                    hold = fsif.iaddr;
                    lat  = zero_wait ? 0 : int'($urandom_range(0, 3));
                end else begin
                    check("iaddr_stable", fsif.iaddr, hold);
                end
                if (lat == 0) begin
                    fsif.idata_ok = 1'b1;
                    fsif.idata    = mem_word(fsif.iaddr);
                    busy          = 1'b0;
                end else begin
                    lat--;
                end
            end else if (busy) begin
                tests++;
                fails++;
                $display("FAIL ireq_dropped: got ireq=0 with request outstanding, required 1");
                busy = 1'b0;
            end
        end
    end

    // Monitor: compare every accepted output against the scoreboard.
    initial begin
        int   idle;
        exp_t e;
        idle = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                idle = 0;
            end else if (fsif.valid_out && !fsif.stall) begin
                idle = 0;
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_empty: got pc_out %h with nothing expected", fsif.pc_out);
                end else begin
                    e = sb_q.pop_front();
                    check("pc_out",    fsif.pc_out,            e.pc);
                    check("instr_out", fsif.instr_out,         e.instr);
                    check("adel_out",  {31'd0, fsif.adel_out}, {31'd0, e.adel});
                end
            end else if (p_stall < 100) begin
                idle++;
                if (idle > 60) begin
                    tests++;
                    fails++;
                    $display("FAIL progress: got %0d idle cycles, required <= 60", idle);
                    idle = 0;
                end
            end
        end
    end

    initial begin
        int n;
        arch_q = '{C_RESET_PC};
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid_out", {31'd0, fsif.valid_out}, 32'd0);
        check("rst_instr_out", fsif.instr_out, 32'd0);
        check("rst_pc_out",    fsif.pc_out,    32'd0);
        check("rst_adel_out",  {31'd0, fsif.adel_out}, 32'd0);
        check("rst_ireq",      {31'd0, fsif.ireq}, 32'd0);
        check("rst_iaddr",     fsif.iaddr, C_RESET_PC);
        reset = 1'b0;

        // Zero-wait streaming: one instruction per cycle, pc_out one cycle behind iaddr.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("zw_ireq",  {31'd0, fsif.ireq}, 32'd1);
            check("zw_iaddr", fsif.iaddr, C_RESET_PC + 32'(4 * i));
            check("zw_valid", {31'd0, fsif.valid_out}, (i > 0) ? 32'd1 : 32'd0);
            if (i > 0) check("zw_pc_out", fsif.pc_out, C_RESET_PC + 32'(4 * (i - 1)));
        end

        // Held stall: slot plus skid fill, then the bus goes quiet.
        p_stall = 100;
        @(negedge clk);
        for (int s = 2; s <= 5; s++) begin
            @(negedge clk);
            check("stall_ireq",  {31'd0, fsif.ireq}, 32'd0);
            check("stall_valid", {31'd0, fsif.valid_out}, 32'd1);
        end
        p_stall = 0;
        repeat (10) @(posedge clk);

        zero_wait = 1'b0;
        p_stall   = 30;
        p_redir   = 20;
        repeat (1500) @(posedge clk);

        // Reset with a request outstanding and the slot full.
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(fsif.ireq && !fsif.idata_ok && fsif.valid_out) && n < 200);
        if (n >= 200) begin
            tests++;
            fails++;
            $display("FAIL rst_mid_setup: got no outstanding request in %0d cycles, required one", n);
        end
        #1 reset = 1'b1;
        #1;
        check("arst_valid_out", {31'd0, fsif.valid_out}, 32'd0);
        check("arst_instr_out", fsif.instr_out, 32'd0);
        check("arst_pc_out",    fsif.pc_out,    32'd0);
        check("arst_adel_out",  {31'd0, fsif.adel_out}, 32'd0);
        check("arst_ireq",      {31'd0, fsif.ireq}, 32'd0);
        sb_q.delete();
        arch_q = '{C_RESET_PC};
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("restart_iaddr", fsif.iaddr, C_RESET_PC);
        check("restart_ireq",  {31'd0, fsif.ireq}, 32'd1);

        zero_wait = 1'b1;
        p_stall   = 20;
        p_redir   = 25;
        repeat (800) @(posedge clk);
        zero_wait = 1'b0;
        repeat (800) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
